ycbcr_to_rgb: RTL and testbench

//   Inverse of the capture-path RGB->YCbCr converter: BT.601 YCbCr 4:4:4 (8b/comp) -> RGB888.

---
 rtl/ycbcr_to_rgb_if.sv | 26 ++
 rtl/ycbcr_to_rgb.sv | 109 ++++++++++
 tb/tb_ycbcr_to_rgb.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ycbcr_to_rgb_if.sv
// Pixel stream bundle for ycbcr_to_rgb: YCbCr plus syncs in, RGB888 plus delayed syncs out.
// master drives the YCbCr side and observes RGB; slave is the converter itself.
interface ycbcr_to_rgb_if;
  logic [7:0] i_y_8b;
  logic [7:0] i_cb_8b;
  logic [7:0] i_cr_8b;
  logic       i_h_sync;
  logic       i_v_sync;
  logic       i_data_en;
  logic [7:0] o_r_8b;
  logic [7:0] o_g_8b;
  logic [7:0] o_b_8b;
  logic       o_h_sync;
  logic       o_v_sync;
  logic       o_data_en;

  modport master (
    output i_y_8b, i_cb_8b, i_cr_8b, i_h_sync, i_v_sync, i_data_en,
    input  o_r_8b, o_g_8b, o_b_8b, o_h_sync, o_v_sync, o_data_en
  );

  modport slave (
    input  i_y_8b, i_cb_8b, i_cr_8b, i_h_sync, i_v_sync, i_data_en,
    output o_r_8b, o_g_8b, o_b_8b, o_h_sync, o_v_sync, o_data_en
  );
endinterface

// File: rtl/ycbcr_to_rgb.sv
// BT.601 YCbCr 4:4:4 to RGB888, four register stages, syncs delayed to stay aligned with data.
// Define YCBCR_TO_RGB_FULL_RANGE_EN for full-range (JPEG) input with fixed coefficients.
module ycbcr_to_rgb #(
  parameter int FRAC_BITS = 8,
  parameter int K_Y       = 298,
  parameter int K_RV      = 409,
  parameter int K_GU      = 100,
  parameter int K_GV      = 208,
  parameter int K_BU      = 516
) (
  input  logic          clk,
  input  logic          rst,
  ycbcr_to_rgb_if.slave pix
);

`ifdef YCBCR_TO_RGB_FULL_RANGE_EN
  localparam int         KY_EFF   = 256;
  localparam int         KRV_EFF  = 359;
  localparam int         KGU_EFF  = 88;
  localparam int         KGV_EFF  = 183;
  localparam int         KBU_EFF  = 454;
  localparam logic [8:0] Y_OFFSET = 9'd0;
`else
  localparam int         KY_EFF   = K_Y;
  localparam int         KRV_EFF  = K_RV;
  localparam int         KGU_EFF  = K_GU;
  localparam int         KGV_EFF  = K_GV;
  localparam int         KBU_EFF  = K_BU;
  localparam logic [8:0] Y_OFFSET = 9'd16;
`endif

  localparam logic signed [19:0] CY    = 20'(KY_EFF);
  localparam logic signed [19:0] CRV   = 20'(KRV_EFF);
  localparam logic signed [19:0] CGU   = 20'(KGU_EFF);
  localparam logic signed [19:0] CGV   = 20'(KGV_EFF);
  localparam logic signed [19:0] CBU   = 20'(KBU_EFF);
  localparam logic signed [19:0] ROUND = 20'(1 << (FRAC_BITS - 1));

  logic signed [8:0]  s1_yo, s1_u, s1_v;
  logic signed [19:0] s2_y, s2_rv, s2_gu, s2_gv, s2_bu;
  logic signed [19:0] s3_r, s3_g, s3_b;
  logic [7:0]         r_q, g_q, b_q;
  logic [3:0]         hs_pipe, vs_pipe, en_pipe;

  // Round half up, then saturate to the 8-bit output range.
  function automatic logic [7:0] clamp8(input logic signed [19:0] s);
    logic signed [19:0] t;
    t = (s + ROUND) >>> FRAC_BITS;
    if (t < 20'sd0)
      return 8'd0;
    else if (t > 20'sd255)
      return 8'hff;
    else
      return t[7:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_yo   <= '0;
      s1_u    <= '0;
      s1_v    <= '0;
      s2_y    <= '0;
      s2_rv   <= '0;
      s2_gu   <= '0;
      s2_gv   <= '0;
      s2_bu   <= '0;
      s3_r    <= '0;
      s3_g    <= '0;
      s3_b    <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hs_pipe <= '0;
      vs_pipe <= '0;
      en_pipe <= '0;
    end else begin
      s1_yo <= $signed({1'b0, pix.i_y_8b} - Y_OFFSET);
      s1_u  <= $signed({1'b0, pix.i_cb_8b} - 9'd128);
      s1_v  <= $signed({1'b0, pix.i_cr_8b} - 9'd128);

      s2_y  <= 20'(s1_yo) * CY;
      s2_rv <= 20'(s1_v)  * CRV;
      s2_gu <= 20'(s1_u)  * CGU;
      s2_gv <= 20'(s1_v)  * CGV;
      s2_bu <= 20'(s1_u)  * CBU;

      // Worst case magnitude stays well inside 20 signed bits, so no guard bits needed.
      s3_r <= s2_y + s2_rv;
      s3_g <= s2_y - s2_gu - s2_gv;
      s3_b <= s2_y + s2_bu;

      r_q <= clamp8(s3_r);
      g_q <= clamp8(s3_g);
      b_q <= clamp8(s3_b);

      hs_pipe <= {hs_pipe[2:0], pix.i_h_sync};
      vs_pipe <= {vs_pipe[2:0], pix.i_v_sync};
      en_pipe <= {en_pipe[2:0], pix.i_data_en};
    end
  end

  assign pix.o_r_8b    = r_q;
  assign pix.o_g_8b    = g_q;
  assign pix.o_b_8b    = b_q;
  assign pix.o_h_sync  = hs_pipe[3];
  assign pix.o_v_sync  = vs_pipe[3];
  assign pix.o_data_en = en_pipe[3];

endmodule

// File: tb/tb_ycbcr_to_rgb.sv
// Self-checking bench for ycbcr_to_rgb: vector table, streaming ramp, mid-frame reset, round trip.
// Expected pixels are queued when driven and compared when their output cycle arrives.
module tb_ycbcr_to_rgb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   errors   = 0;
  int   cycle    = 0;
  int   sinceRst = 0;

  typedef struct {
    logic [7:0] r, g, b;
    logic       hs, vs, en;
    int         tol;
    int         due;
  } exp_t;

  typedef struct {
    logic [7:0] y, cb, cr, r, g, b;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  ycbcr_to_rgb_if px();

  ycbcr_to_rgb dut (
    .clk (clk),
    .rst (rst),
    .pix (px)
  );

  always #5 clk = ~clk;

  // Integer reference straight from the conversion equations.
  function automatic int fixClamp(input int x);
    int t;
    t = (x + 128) >>> 8;
    if (t < 0) return 0;
    if (t > 255) return 255;
    return t;
  endfunction

  function automatic void model(input int y, input int cb, input int cr,
                                output int r, output int g, output int b);
    int yo, u, v;
    u = cb - 128;
    v = cr - 128;
`ifdef YCBCR_TO_RGB_FULL_RANGE_EN
    yo = y;
    r = fixClamp(256 * yo + 359 * v);
    g = fixClamp(256 * yo - 88 * u - 183 * v);
    b = fixClamp(256 * yo + 454 * u);
`else
    yo = y - 16;
    r = fixClamp(298 * yo + 409 * v);
    g = fixClamp(298 * yo - 100 * u - 208 * v);
    b = fixClamp(298 * yo + 516 * u);
`endif
  endfunction

  function automatic int absDiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic applyStimulus(input int y, input int cb, input int cr,
                               input logic hs, input logic vs, input logic en,
                               input logic rstVal,
                               input int er, input int eg, input int eb, input int tol);
    @(negedge clk);
    px.i_y_8b    = 8'(y);
    px.i_cb_8b   = 8'(cb);
    px.i_cr_8b   = 8'(cr);
    px.i_h_sync  = hs;
    px.i_v_sync  = vs;
    px.i_data_en = en;
    rst          = rstVal;
    if (!rstVal)
      sb.push_back('{8'(er), 8'(eg), 8'(eb), hs, vs, en, tol, cycle + 4});
  endtask

  task automatic drivePixel(input int y, input int cb, input int cr,
                            input logic hs, input logic vs, input logic en);
    int r, g, b;
    model(y, cb, cr, r, g, b);
    applyStimulus(y, cb, cr, hs, vs, en, 1'b0, r, g, b, 0);
  endtask

  task automatic checkZero(input string name);
    checks++;
    if ({px.o_r_8b, px.o_g_8b, px.o_b_8b, px.o_h_sync, px.o_v_sync, px.o_data_en} != '0) begin
      errors++;
      $display("[TB] FAIL %s@%0d got rgb=%0d,%0d,%0d syncs(h,v,en)=%b%b%b required all zero",
               name, cycle, px.o_r_8b, px.o_g_8b, px.o_b_8b,
               px.o_h_sync, px.o_v_sync, px.o_data_en);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (rst) begin
      sb.delete();
      sinceRst = 0;
      checkZero("reset");
      return;
    end
    sinceRst++;
    while (sb.size() > 0 && sb[0].due < cycle) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missed_pixel due@%0d now@%0d got no output slot required rgb=%0d,%0d,%0d",
               e.due, cycle, e.r, e.g, e.b);
    end
    if (sb.size() > 0 && sb[0].due == cycle) begin
      e = sb.pop_front();
      checks++;
      if (absDiff(int'(px.o_r_8b), int'(e.r)) > e.tol ||
          absDiff(int'(px.o_g_8b), int'(e.g)) > e.tol ||
          absDiff(int'(px.o_b_8b), int'(e.b)) > e.tol ||
          {px.o_h_sync, px.o_v_sync, px.o_data_en} != {e.hs, e.vs, e.en}) begin
        errors++;
        $display("[TB] FAIL pixel@%0d got rgb=%0d,%0d,%0d syncs=%b%b%b required rgb=%0d,%0d,%0d (tol %0d) syncs=%b%b%b",
                 cycle, px.o_r_8b, px.o_g_8b, px.o_b_8b,
                 px.o_h_sync, px.o_v_sync, px.o_data_en,
                 e.r, e.g, e.b, e.tol, e.hs, e.vs, e.en);
      end
    end else if (sinceRst <= 3) begin
      checkZero("post_reset");
    end
  endtask

  always @(posedge clk) begin
    #1;
    cycle++;
    checkOutput();
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int ry, rcb, rcr, sr, sg, sb8;

`ifdef YCBCR_TO_RGB_FULL_RANGE_EN
    vecs[0] = '{8'd200, 8'd128, 8'd128, 8'd200, 8'd200, 8'd200};
    vecs[1] = '{8'd0,   8'd128, 8'd128, 8'd0,   8'd0,   8'd0};
    vecs[2] = '{8'd255, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255};
    vecs[3] = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128};
    vecs[4] = '{8'd255, 8'd128, 8'd255, 8'd255, 8'd164, 8'd255};
    vecs[5] = '{8'd0,   8'd255, 8'd128, 8'd0,   8'd0,   8'd225};
`else
    vecs[0] = '{8'd16,  8'd128, 8'd128, 8'd0,   8'd0,   8'd0};
    vecs[1] = '{8'd235, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255};
    vecs[2] = '{8'd255, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255};
    vecs[3] = '{8'd0,   8'd128, 8'd128, 8'd0,   8'd0,   8'd0};
    vecs[4] = '{8'd81,  8'd90,  8'd240, 8'd255, 8'd0,   8'd0};
    vecs[5] = '{8'd126, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128};
`endif

    px.i_y_8b    = 8'd200;
    px.i_cb_8b   = 8'd50;
    px.i_cr_8b   = 8'd60;
    px.i_h_sync  = 1'b1;
    px.i_v_sync  = 1'b1;
    px.i_data_en = 1'b1;

    $display("[TB] reset with nonzero inputs");
    for (int i = 0; i < 3; i++)
      applyStimulus(200, 50, 60, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0);

    $display("[TB] vector table");
    for (int i = 0; i < 6; i++)
      applyStimulus(int'(vecs[i].y), int'(vecs[i].cb), int'(vecs[i].cr),
                    1'b0, 1'b0, 1'b1, 1'b0,
                    int'(vecs[i].r), int'(vecs[i].g), int'(vecs[i].b), 0);

    $display("[TB] streaming ramp with sync toggles");
    for (int i = 0; i < 24; i++)
      drivePixel(16 + i * 9, 98 + (i * 11) % 60, 158 - (i * 7) % 60,
                 (i % 7) == 0, i == 3, (i % 5) != 0);

    $display("[TB] mid-frame reset flush");
    for (int i = 0; i < 3; i++)
      drivePixel(180, 100 + i, 150, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++)
      applyStimulus(240, 20, 230, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0);
    drivePixel(100, 140, 110, 1'b0, 1'b1, 1'b1);
    drivePixel(60, 200, 40, 1'b1, 1'b0, 1'b0);
    drivePixel(235, 16, 240, 1'b0, 1'b0, 1'b1);

`ifndef YCBCR_TO_RGB_FULL_RANGE_EN
    $display("[TB] random RGB round trip");
    for (int i = 0; i < 24; i++) begin
      sr  = int'($urandom_range(0, 255));
      sg  = int'($urandom_range(0, 255));
      sb8 = int'($urandom_range(0, 255));
      ry  = ((66 * sr + 129 * sg + 25 * sb8 + 128) >>> 8) + 16;
      rcb = ((-38 * sr - 74 * sg + 112 * sb8 + 128) >>> 8) + 128;
      rcr = ((112 * sr - 94 * sg - 18 * sb8 + 128) >>> 8) + 128;
      applyStimulus(ry, rcb, rcr, 1'b0, 1'b0, 1'b1, 1'b0, sr, sg, sb8, 3);
    end
`endif

    repeat (8) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got %0d pixels still pending required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
